// File: rtl/modulation_symbol_scheduler_if.sv
`default_nettype none
// ============================================================================
// Module      : modulation_symbol_scheduler_if
// Description : Control and data bundle between the symbol scheduler, the LFSR
//               and the carrier modulator.
// Revision    : 1.0 - initial release
// ============================================================================
interface modulation_symbol_scheduler_if;
  logic        enable;
  logic [2:0]  mode_req;
  logic [31:0] symbol_period;
  logic [4:0]  rand_bits;
  logic        lfsr_advance;
  logic [1:0]  modulating_bits;
  logic [2:0]  modulation_selector;
  logic [31:0] fsk_dds_increment;
  logic        symbol_strobe;
  logic        mute;

  modport master (
    output enable, mode_req, symbol_period, rand_bits,
    input  lfsr_advance, modulating_bits, modulation_selector,
           fsk_dds_increment, symbol_strobe, mute
  );

  modport slave (
    input  enable, mode_req, symbol_period, rand_bits,
    output lfsr_advance, modulating_bits, modulation_selector,
           fsk_dds_increment, symbol_strobe, mute
  );
endinterface
`default_nettype wire

// File: rtl/modulation_symbol_scheduler.sv
`default_nettype none
// ============================================================================
// Module      : modulation_symbol_scheduler
// Description : Paces symbol boundaries, draws LFSR bits per symbol and inserts
//               a muted guard interval when the modulation mode changes.
// Revision    : 1.0 - initial release
// ============================================================================
module modulation_symbol_scheduler #(
  parameter logic [31:0] FSK_INCR_0   = 32'd172,
  parameter logic [31:0] FSK_INCR_1   = 32'd344,
  parameter int unsigned MUTE_SYMBOLS = 1
) (
  input  wire logic                    clk,
  input  wire logic                    reset,
  modulation_symbol_scheduler_if.slave bus
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_MUTE = 2'd2
  } state_t;

  localparam logic [3:0] c_last_guard = 4'(MUTE_SYMBOLS - 1);

  state_t      r_state, w_state_nxt;
  logic [31:0] r_cnt, w_cnt_nxt;
  logic [3:0]  r_guard, w_guard_nxt;
  logic [1:0]  r_bits, w_bits_nxt;
  logic [2:0]  r_sel, w_sel_nxt;
  logic [31:0] r_incr, w_incr_nxt;
  logic        r_mute, w_mute_nxt;
  logic        r_adv, w_adv_nxt;
  logic        r_strobe, w_strobe_nxt;

  logic [31:0] w_period;
  logic        w_boundary;
  logic [2:0]  w_mode;
  logic        w_load;
  logic [2:0]  w_load_sel;
  logic        w_unused_rand;

  assign w_period      = (bus.symbol_period < 32'd2) ? 32'd2 : bus.symbol_period;
  // >= so a period shortened mid-symbol terminates the symbol immediately
  assign w_boundary    = (r_cnt >= (w_period - 32'd1));
  assign w_mode        = (bus.mode_req > 3'd4) ? 3'd0 : bus.mode_req;
  assign w_unused_rand = ^bus.rand_bits[4:2];

  always_comb begin
    w_state_nxt  = r_state;
    w_cnt_nxt    = r_cnt;
    w_guard_nxt  = r_guard;
    w_bits_nxt   = r_bits;
    w_sel_nxt    = r_sel;
    w_incr_nxt   = r_incr;
    w_mute_nxt   = r_mute;
    w_adv_nxt    = 1'b0;
    w_strobe_nxt = 1'b0;
    w_load       = 1'b0;
    w_load_sel   = r_sel;

    case (r_state)
      S_IDLE: begin
        if (bus.enable) begin
          w_load      = 1'b1;
          w_load_sel  = w_mode;
          w_state_nxt = S_RUN;
        end
      end
      S_RUN: begin
        if (!w_boundary) begin
          w_cnt_nxt = r_cnt + 32'd1;
        end else if (!bus.enable) begin
          w_state_nxt = S_IDLE;
          w_mute_nxt  = 1'b1;
          w_bits_nxt  = 2'b00;
          w_cnt_nxt   = 32'd0;
        end else if (w_mode != r_sel) begin
          w_state_nxt = S_MUTE;
          w_sel_nxt   = w_mode;
          w_bits_nxt  = 2'b00;
          w_mute_nxt  = 1'b1;
          w_cnt_nxt   = 32'd0;
          w_guard_nxt = 4'd0;
        end else begin
          w_load = 1'b1;
        end
      end
      S_MUTE: begin
        if (!bus.enable) begin
          w_state_nxt = S_IDLE;
          w_cnt_nxt   = 32'd0;
        end else if (!w_boundary) begin
          w_cnt_nxt = r_cnt + 32'd1;
        end else if (r_guard == c_last_guard) begin
          w_load      = 1'b1;
          w_state_nxt = S_RUN;
        end else begin
          w_cnt_nxt   = 32'd0;
          w_guard_nxt = r_guard + 4'd1;
        end
      end
      default: begin
        w_state_nxt = S_IDLE;
        w_mute_nxt  = 1'b1;
        w_bits_nxt  = 2'b00;
        w_cnt_nxt   = 32'd0;
      end
    endcase

    // Bits are captured on this edge; the LFSR steps afterwards on lfsr_advance
    if (w_load) begin
      w_sel_nxt    = w_load_sel;
      w_bits_nxt   = (w_load_sel == 3'b100) ? bus.rand_bits[1:0] : {1'b0, bus.rand_bits[0]};
      w_incr_nxt   = bus.rand_bits[0] ? FSK_INCR_1 : FSK_INCR_0;
      w_strobe_nxt = 1'b1;
      w_adv_nxt    = 1'b1;
      w_cnt_nxt    = 32'd0;
      w_mute_nxt   = 1'b0;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state  <= S_IDLE;
      r_cnt    <= 32'd0;
      r_guard  <= 4'd0;
      r_bits   <= 2'b00;
      r_sel    <= 3'b000;
      r_incr   <= FSK_INCR_0;
      r_mute   <= 1'b1;
      r_adv    <= 1'b0;
      r_strobe <= 1'b0;
    end else begin
      r_state  <= w_state_nxt;
      r_cnt    <= w_cnt_nxt;
      r_guard  <= w_guard_nxt;
      r_bits   <= w_bits_nxt;
      r_sel    <= w_sel_nxt;
      r_incr   <= w_incr_nxt;
      r_mute   <= w_mute_nxt;
      r_adv    <= w_adv_nxt;
      r_strobe <= w_strobe_nxt;
    end
  end

  assign bus.lfsr_advance        = r_adv;
  assign bus.modulating_bits     = r_bits;
  assign bus.modulation_selector = r_sel;
  assign bus.fsk_dds_increment   = r_incr;
  assign bus.symbol_strobe       = r_strobe;
  assign bus.mute                = r_mute;

endmodule
`default_nettype wire

// File: tb/tb_modulation_symbol_scheduler.sv
`default_nettype none
// ============================================================================
// Module      : tb_modulation_symbol_scheduler
// Description : Scoreboard bench; expected symbols are queued by the stimulus
//               and popped by a monitor on every symbol_strobe.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_modulation_symbol_scheduler;

  typedef struct {
    logic [1:0]  bits;
    logic [2:0]  sel;
    logic [31:0] incr;
    int          gap;
  } exp_t;

  logic clk;
  logic reset;
  int   n_cmp;
  int   n_err;
  int   stray_adv;
  exp_t q[$];

  modulation_symbol_scheduler_if bus ();

  modulation_symbol_scheduler #(
    .FSK_INCR_0   (32'd172),
    .FSK_INCR_1   (32'd344),
    .MUTE_SYMBOLS (1)
  ) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic push(input logic [1:0] bits, input logic [2:0] sel,
                      input logic [31:0] incr, input int gap);
    exp_t e;
    e.bits = bits;
    e.sel  = sel;
    e.incr = incr;
    e.gap  = gap;
    q.push_back(e);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_strobe(input string name, input int budget);
    bit seen = 1'b0;
    for (int i = 0; i < budget && !seen; i++) begin
      tick();
      if (bus.symbol_strobe === 1'b1) seen = 1'b1;
    end
    check(name, {31'd0, seen}, 32'd1);
  endtask

  // Called right after a strobe sample with enable dropped: symbol must finish first
  task automatic to_idle(input int p);
    bus.enable = 1'b0;
    repeat (p - 1) tick();
    check("mid_symbol_mute", {31'd0, bus.mute}, 32'd0);
    tick();
    check("idle_mute", {31'd0, bus.mute}, 32'd1);
    check("idle_bits", {30'd0, bus.modulating_bits}, 32'd0);
  endtask

  // Monitor: each strobe must match the oldest queued symbol
  initial begin : monitor
    int   cycle;
    int   last;
    exp_t e;
    cycle = 0;
    last  = 0;
    forever begin
      @(negedge clk);
      cycle++;
      if (bus.lfsr_advance !== bus.symbol_strobe) stray_adv++;
      if (bus.symbol_strobe === 1'b1) begin
        if (q.size() == 0) begin
          n_cmp++;
          n_err++;
          $display("FAIL unexpected_strobe: got strobe with empty queue, expected none at %0t", $time);
        end else begin
          e = q.pop_front();
          check("sym_bits", {30'd0, bus.modulating_bits}, {30'd0, e.bits});
          check("sym_sel", {29'd0, bus.modulation_selector}, {29'd0, e.sel});
          check("sym_incr", bus.fsk_dds_increment, e.incr);
          check("sym_mute", {31'd0, bus.mute}, 32'd0);
          check("sym_adv", {31'd0, bus.lfsr_advance}, 32'd1);
          if (e.gap != 0) check("sym_gap", 32'(cycle - last), 32'(e.gap));
        end
        last = cycle;
      end
    end
  end

  initial begin : watchdog
    #200000;
    $display("FAIL watchdog: got no completion, expected finish before time limit");
    $fatal(1, "time limit");
  end

  initial begin : stimulus
    int muted;
    bit seen;
    n_cmp     = 0;
    n_err     = 0;
    stray_adv = 0;

    // Reset with arbitrary, active-looking inputs
    reset             = 1'b1;
    bus.enable        = 1'b1;
    bus.mode_req      = 3'b100;
    bus.symbol_period = 32'd7;
    bus.rand_bits     = 5'b11111;
    repeat (3) tick();
    check("rst_mute", {31'd0, bus.mute}, 32'd1);
    check("rst_bits", {30'd0, bus.modulating_bits}, 32'd0);
    check("rst_sel", {29'd0, bus.modulation_selector}, 32'd0);
    check("rst_incr", bus.fsk_dds_increment, 32'd172);
    check("rst_strobe", {31'd0, bus.symbol_strobe}, 32'd0);
    check("rst_adv", {31'd0, bus.lfsr_advance}, 32'd0);
    bus.enable = 1'b0;
    reset      = 1'b0;
    repeat (2) tick();

    // ASK, P=4: one-edge latency, strobe every 4 cycles
    bus.symbol_period = 32'd4;
    bus.mode_req      = 3'b000;
    bus.rand_bits     = 5'b00001;
    push(2'b01, 3'b000, 32'd344, 0);
    push(2'b01, 3'b000, 32'd344, 4);
    push(2'b01, 3'b000, 32'd344, 4);
    bus.enable = 1'b1;
    tick();
    check("latency_strobe", {31'd0, bus.symbol_strobe}, 32'd1);
    check("latency_mute", {31'd0, bus.mute}, 32'd0);
    check("latency_bits", {30'd0, bus.modulating_bits}, 32'd1);
    wait_strobe("ask_strobe2", 8);
    wait_strobe("ask_strobe3", 8);
    to_idle(4);

    // QPSK
    bus.mode_req  = 3'b100;
    bus.rand_bits = 5'b10110;
    push(2'b10, 3'b100, 32'd172, 0);
    push(2'b10, 3'b100, 32'd172, 4);
    bus.enable = 1'b1;
    wait_strobe("qpsk_strobe1", 4);
    wait_strobe("qpsk_strobe2", 8);
    to_idle(4);

    // FSK: bit 1 then bit 0
    bus.mode_req  = 3'b001;
    bus.rand_bits = 5'b00001;
    push(2'b01, 3'b001, 32'd344, 0);
    push(2'b00, 3'b001, 32'd172, 4);
    bus.enable = 1'b1;
    wait_strobe("fsk_strobe1", 4);
    bus.rand_bits = 5'b00000;
    wait_strobe("fsk_strobe2", 8);
    to_idle(4);

    // ASK -> BPSK mid-symbol: symbol completes, 4 guard cycles, then BPSK
    bus.mode_req  = 3'b000;
    bus.rand_bits = 5'b00001;
    push(2'b01, 3'b000, 32'd344, 0);
    push(2'b01, 3'b010, 32'd344, 8);
    bus.enable = 1'b1;
    wait_strobe("mc_strobe1", 4);
    tick();
    bus.mode_req = 3'b010;
    muted = 0;
    seen  = 1'b0;
    for (int i = 0; i < 20 && !seen; i++) begin
      tick();
      if (bus.symbol_strobe === 1'b1) seen = 1'b1;
      else if (bus.mute === 1'b1 && bus.modulating_bits === 2'b00 &&
               bus.modulation_selector === 3'b010) muted++;
    end
    check("guard_cycles", 32'(muted), 32'd4);
    check("guard_end_strobe", {31'd0, seen}, 32'd1);
    to_idle(4);

    // symbol_period=0 behaves as 2; then asynchronous reset mid-RUN
    bus.symbol_period = 32'd0;
    bus.mode_req      = 3'b100;
    bus.rand_bits     = 5'b00011;
    push(2'b11, 3'b100, 32'd344, 0);
    push(2'b11, 3'b100, 32'd344, 2);
    push(2'b11, 3'b100, 32'd344, 2);
    bus.enable = 1'b1;
    wait_strobe("p0_strobe1", 4);
    wait_strobe("p0_strobe2", 4);
    wait_strobe("p0_strobe3", 4);
    tick();
    #2;
    reset = 1'b1;
    #1;
    check("arst_mute", {31'd0, bus.mute}, 32'd1);
    check("arst_bits", {30'd0, bus.modulating_bits}, 32'd0);
    check("arst_sel", {29'd0, bus.modulation_selector}, 32'd0);
    check("arst_incr", bus.fsk_dds_increment, 32'd172);
    bus.enable = 1'b0;
    repeat (2) tick();
    reset = 1'b0;
    repeat (4) tick();

    check("queue_empty", 32'(q.size()), 32'd0);
    check("stray_adv", 32'(stray_adv), 32'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
`default_nettype wire
